mem_arbiter: RTL and testbench

Two-requester arbiter for the single-port synchronous data memory (registered read, 1-cycle latency).

---
 rtl/mem_arbiter_if.sv | 16 +
 rtl/mem_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Request/acknowledge channel between one memory master and the memory arbiter.
// The master drives the request fields; the arbiter returns the ack pulse and read data.
interface mem_arbiter_if #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 16
);
   logic                  req;
   logic                  we;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] data;
   logic                  ack;
   logic [DATA_WIDTH-1:0] rdata;

   modport master (output req, we, addr, data, input ack, rdata);
   modport slave  (input req, we, addr, data, output ack, rdata);
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving two masters serialized access to a single-port memory
// with registered (1-cycle) read latency; IDLE -> ACCESS -> RESP per transaction.
module mem_arbiter #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   mem_arbiter_if.slave          r0_if,
   mem_arbiter_if.slave          r1_if,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_data_o,
   input  logic [DATA_WIDTH-1:0] mem_out_i,
   output logic                  busy_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t                state_q;
   logic                  owner_q;
   logic                  last_grant_q;
   logic                  ack0_q;
   logic                  ack1_q;
   logic                  busy_q;
   logic                  mem_we_q;
   logic [ADDR_WIDTH-1:0] mem_addr_q;
   logic [DATA_WIDTH-1:0] mem_data_q;

   logic                  cand0_s;
   logic                  cand1_s;
   logic                  grant_s;
   logic                  winner_s;
   logic                  win_we_s;
   logic [ADDR_WIDTH-1:0] win_addr_s;
   logic [DATA_WIDTH-1:0] win_data_s;

   // Arbitration: the owner's request is stale during RESP and must not win again.
   always_comb begin
      cand0_s = r0_if.req && !((state_q == RESP) && (owner_q == 1'b0));
      cand1_s = r1_if.req && !((state_q == RESP) && (owner_q == 1'b1));
      grant_s = ((state_q == IDLE) || (state_q == RESP)) && (cand0_s || cand1_s);
      if (cand0_s && cand1_s) begin
         winner_s = ~last_grant_q;
      end else begin
         winner_s = cand1_s;
      end
      if (winner_s) begin
         win_we_s   = r1_if.we;
         win_addr_s = r1_if.addr;
         win_data_s = r1_if.data;
      end else begin
         win_we_s   = r0_if.we;
         win_addr_s = r0_if.addr;
         win_data_s = r0_if.data;
      end
   end

   // Transaction FSM with registered memory controls, acks and busy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         busy_q       <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= {ADDR_WIDTH{1'b0}};
         mem_data_q   <= {DATA_WIDTH{1'b0}};
      end else begin
         case (state_q)
            IDLE, RESP: begin
               ack0_q <= 1'b0;
               ack1_q <= 1'b0;
               if (grant_s) begin
                  state_q      <= ACCESS;
                  busy_q       <= 1'b1;
                  owner_q      <= winner_s;
                  last_grant_q <= winner_s;
                  mem_we_q     <= win_we_s;
                  mem_addr_q   <= win_addr_s;
                  mem_data_q   <= win_data_s;
               end else begin
                  state_q  <= IDLE;
                  busy_q   <= 1'b0;
                  mem_we_q <= 1'b0;
               end
            end
            ACCESS: begin
               state_q  <= RESP;
               busy_q   <= 1'b1;
               mem_we_q <= 1'b0;
               ack0_q   <= ~owner_q;
               ack1_q   <= owner_q;
            end
            default: begin
               state_q  <= IDLE;
               busy_q   <= 1'b0;
               mem_we_q <= 1'b0;
               ack0_q   <= 1'b0;
               ack1_q   <= 1'b0;
            end
         endcase
      end
   end

   assign mem_we_o   = mem_we_q;
   assign mem_addr_o = mem_addr_q;
   assign mem_data_o = mem_data_q;
   assign busy_o     = busy_q;

   // Read data comes straight from the memory; it is only meaningful alongside a read ack.
   assign r0_if.ack   = ack0_q;
   assign r1_if.ack   = ack1_q;
   assign r0_if.rdata = mem_out_i;
   assign r1_if.rdata = mem_out_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: per-port request drivers, a memory model,
// and a monitor that checks every ack against a transaction-level reference memory.
module tb_mem_arbiter;
   localparam int AW = 6;
   localparam int DW = 16;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      int            gap;
   } txn_t;

   typedef struct {
      int port;
      int cyc;
   } ack_rec_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data;
   logic [DW-1:0] mem_out = '0;
   logic          busy;

   logic          req_v  [2];
   logic          we_v   [2];
   logic [AW-1:0] addr_v [2];
   logic [DW-1:0] data_v [2];

   logic [DW-1:0] mem     [64];
   logic [DW-1:0] ref_mem [64];

   txn_t     cmd_q [2][$];
   txn_t     exp_q [2][$];
   ack_rec_t ack_log [$];

   int cyc     = 0;
   int n_checks = 0;
   int n_fail   = 0;

   mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) r0_if ();
   mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) r1_if ();

   assign r0_if.req  = req_v[0];
   assign r0_if.we   = we_v[0];
   assign r0_if.addr = addr_v[0];
   assign r0_if.data = data_v[0];
   assign r1_if.req  = req_v[1];
   assign r1_if.we   = we_v[1];
   assign r1_if.addr = addr_v[1];
   assign r1_if.data = data_v[1];

   mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk        (clk),
      .rst        (rst),
      .r0_if      (r0_if),
      .r1_if      (r1_if),
      .mem_we_o   (mem_we),
      .mem_addr_o (mem_addr),
      .mem_data_o (mem_data),
      .mem_out_i  (mem_out),
      .busy_o     (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Single-port synchronous memory with registered read.
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_data;
      mem_out <= mem[mem_addr];
   end

   function automatic logic ack_of(input int p);
      return (p == 1) ? r1_if.ack : r0_if.ack;
   endfunction

   function automatic logic [DW-1:0] rdata_of(input int p);
      return (p == 1) ? r1_if.rdata : r0_if.rdata;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Requester: presents queued transactions one at a time, holding req until ack.
   task automatic drive_port(input int p);
      bit active = 1'b0;
      int wait_n = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            active   = 1'b0;
            wait_n   = 0;
            req_v[p] = 1'b0;
         end else begin
            if (active && ack_of(p)) begin
               active   = 1'b0;
               req_v[p] = 1'b0;
               void'(cmd_q[p].pop_front());
            end
            if (!active && cmd_q[p].size() > 0) begin
               if (wait_n < cmd_q[p][0].gap) begin
                  wait_n++;
               end else begin
                  wait_n    = 0;
                  active    = 1'b1;
                  req_v[p]  = 1'b1;
                  we_v[p]   = cmd_q[p][0].we;
                  addr_v[p] = cmd_q[p][0].addr;
                  data_v[p] = cmd_q[p][0].data;
                  exp_q[p].push_back(cmd_q[p][0]);
               end
            end
         end
      end
   endtask

   initial drive_port(0);
   initial drive_port(1);

   // Monitor: each ack retires the oldest outstanding transaction of that port, in ack order.
   always @(negedge clk) begin : monitor
      txn_t e;
      if (!rst) begin
         if (r0_if.ack || r1_if.ack) begin
            chk("ack_onehot", {31'd0, r0_if.ack & r1_if.ack}, 32'd0);
            chk("no_we_in_resp", {31'd0, mem_we}, 32'd0);
         end
         for (int p = 0; p < 2; p++) begin
            if (ack_of(p)) begin
               ack_log.push_back('{port: p, cyc: cyc});
               if (exp_q[p].size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL spurious_ack: port %0d acked with no outstanding request", p);
               end else begin
                  e = exp_q[p].pop_front();
                  if (!e.we) begin
                     chk($sformatf("rdata_p%0d", p), {16'd0, rdata_of(p)}, {16'd0, ref_mem[e.addr]});
                  end else begin
                     chk($sformatf("wdata_p%0d", p), {16'd0, mem[e.addr]}, {16'd0, e.data});
                     ref_mem[e.addr] <= e.data;
                  end
               end
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic push(input int p, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] data, input int gap);
      txn_t t;
      t.we   = we;
      t.addr = addr;
      t.data = data;
      t.gap  = gap;
      cmd_q[p].push_back(t);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      for (int p = 0; p < 2; p++) begin
         cmd_q[p].delete();
         exp_q[p].delete();
      end
      repeat (3) tick();
      rst = 1'b0;
   endtask

   task automatic wait_drain(input string name, input int bound);
      int n = 0;
      while ((cmd_q[0].size() + cmd_q[1].size() + exp_q[0].size() + exp_q[1].size() != 0
              || busy) && n < bound) begin
         tick();
         n++;
      end
      chk({name, "_drained"}, {31'd0, n < bound}, 32'd1);
   endtask

   initial begin : main
      int c;
      for (int i = 0; i < 2; i++) begin
         req_v[i]  = 1'b0;
         we_v[i]   = 1'b0;
         addr_v[i] = '0;
         data_v[i] = '0;
      end
      for (int i = 0; i < 64; i++) begin
         mem[i]     <= 16'(i * 257) ^ 16'h5A5A;
         ref_mem[i] <= 16'(i * 257) ^ 16'h5A5A;
      end
      mem[5]     <= 16'h1234;
      ref_mem[5] <= 16'h1234;

      tick();
      chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
      chk("rst_mem_addr", {26'd0, mem_addr}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_acks", {30'd0, r1_if.ack, r0_if.ack}, 32'd0);
      do_reset();

      // Both ports request on the first cycle after reset: port 0 first, port 1 back-to-back.
      push(0, 1'b0, 6'd1, 16'h0, 0);
      push(1, 1'b0, 6'd2, 16'h0, 0);
      tick();
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk($sformatf("t3_busy_%0d", k), {31'd0, busy}, 32'd1);
         if (k == 2) chk("t3_ack0", {30'd0, r1_if.ack, r0_if.ack}, 32'd1);
         if (k == 3) chk("t3_addr1", {26'd0, mem_addr}, 32'd2);
         if (k == 4) chk("t3_ack1", {30'd0, r1_if.ack, r0_if.ack}, 32'd2);
      end
      tick();
      chk("t3_idle", {31'd0, busy}, 32'd0);
      wait_drain("t3", 50);

      // Continuous contention: strict alternation starting with port 0, one ack every 2 cycles.
      ack_log.delete();
      for (int i = 0; i < 8; i++) begin
         push(0, 1'(i % 2), 6'(16 + i), 16'($urandom), 0);
         push(1, 1'((i + 1) % 2), 6'(32 + i), 16'($urandom), 0);
      end
      tick();
      c = cyc;
      wait_drain("t4", 200);
      chk("t4_count", ack_log.size(), 32'd16);
      for (int i = 0; i < ack_log.size() && i < 16; i++) begin
         chk($sformatf("t4_port_%0d", i), ack_log[i].port, i % 2);
         chk($sformatf("t4_cyc_%0d", i), ack_log[i].cyc - c, 2 + 2 * i);
      end

      // Single requester: 3-cycle spacing.
      ack_log.delete();
      for (int i = 0; i < 3; i++) push(0, 1'b0, 6'(40 + i), 16'h0, 0);
      tick();
      c = cyc;
      wait_drain("t5", 100);
      chk("t5_count", ack_log.size(), 32'd3);
      for (int i = 0; i < ack_log.size() && i < 3; i++) begin
         chk($sformatf("t5_port_%0d", i), ack_log[i].port, 32'd0);
         chk($sformatf("t5_cyc_%0d", i), ack_log[i].cyc - c, 2 + 3 * i);
      end

      // Port 0 read of preloaded word: address at t+1, ack with data at t+2.
      push(0, 1'b0, 6'd5, 16'h0, 0);
      tick();
      tick();
      chk("t1_addr", {26'd0, mem_addr}, 32'd5);
      chk("t1_we", {31'd0, mem_we}, 32'd0);
      chk("t1_busy", {31'd0, busy}, 32'd1);
      tick();
      chk("t1_ack", {30'd0, r1_if.ack, r0_if.ack}, 32'd1);
      chk("t1_rdata", {16'd0, r0_if.rdata}, 32'h1234);
      wait_drain("t1", 50);

      // Port 1 write then port 0 read-back of the same word.
      push(1, 1'b1, 6'd10, 16'hBEEF, 0);
      tick();
      tick();
      chk("t2_we", {31'd0, mem_we}, 32'd1);
      chk("t2_addr", {26'd0, mem_addr}, 32'd10);
      chk("t2_data", {16'd0, mem_data}, 32'hBEEF);
      tick();
      chk("t2_we_drop", {31'd0, mem_we}, 32'd0);
      chk("t2_ack1", {30'd0, r1_if.ack, r0_if.ack}, 32'd2);
      wait_drain("t2w", 50);
      push(0, 1'b0, 6'd10, 16'h0, 0);
      tick();
      tick();
      tick();
      chk("t2_ack0", {31'd0, r0_if.ack}, 32'd1);
      chk("t2_rdata", {16'd0, r0_if.rdata}, 32'hBEEF);
      wait_drain("t2r", 50);

      // Reset in the middle of a port 1 write: abandoned, no ack, memory untouched.
      push(1, 1'b1, 6'd20, 16'hCAFE, 0);
      tick();
      tick();
      chk("t6_we_before", {31'd0, mem_we}, 32'd1);
      rst = 1'b1;
      #1;
      chk("t6_we_drop", {31'd0, mem_we}, 32'd0);
      chk("t6_busy", {31'd0, busy}, 32'd0);
      for (int p = 0; p < 2; p++) begin
         cmd_q[p].delete();
         exp_q[p].delete();
      end
      repeat (3) begin
         tick();
         chk("t6_no_ack", {31'd0, r1_if.ack}, 32'd0);
      end
      chk("t6_mem_kept", {16'd0, mem[20]}, {16'd0, ref_mem[20]});
      rst = 1'b0;
      ack_log.delete();
      push(0, 1'b0, 6'd20, 16'h0, 0);
      push(1, 1'b0, 6'd21, 16'h0, 0);
      wait_drain("t6", 50);
      chk("t6_count", ack_log.size(), 32'd2);
      if (ack_log.size() == 2) begin
         chk("t6_first", ack_log[0].port, 32'd0);
         chk("t6_second", ack_log[1].port, 32'd1);
      end

      // Random mixed traffic with random gaps over a small address range.
      for (int i = 0; i < 160; i++) begin
         push(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              6'($urandom_range(0, 15)), 16'($urandom), int'($urandom_range(0, 3)));
      end
      wait_drain("rand", 5000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
